// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register responder.
//   state_t        : FSM states of i2c_reg_slave.
//   I2C_WRITE/READ : value of the R/W bit in the address byte.
//   *_DEV_ADDR     : 7-bit target addresses of the devices this block emulates.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      ADDR      = 4'd1,
      ADDR_ACK  = 4'd2,
      SUB       = 4'd3,
      SUB_ACK   = 4'd4,
      WDATA     = 4'd5,
      WDATA_ACK = 4'd6,
      RDATA     = 4'd7,
      RACK      = 4'd8,
      WAIT_STOP = 4'd9
   } state_t;

   localparam logic I2C_WRITE = 1'b0;
   localparam logic I2C_READ  = 1'b1;

   localparam logic [6:0] CODEC_DEV_ADDR = 7'h1A;
   localparam logic [6:0] VIDEO_DEV_ADDR = 7'h20;

endpackage

// File: rtl/i2c_bus_sync.sv
// Pad synchroniser and bus event detector for SCL/SDA.
//   iCLK, iRST         : system clock, synchronous active-high reset
//   iSCL, iSDA         : raw pad inputs (asynchronous)
//   oSDA               : synchronised SDA
//   oSCL_RISE/FALL     : one-cycle pulses on synchronised SCL edges
//   oSTART / oSTOP     : one-cycle pulses for START / STOP conditions
// SYNC_STAGES must be at least 2. Every flop resets to 1 so the bus reads as
// idle and no false edge or START is seen when reset is released.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic iCLK,
   input  logic iRST,
   input  logic iSCL,
   input  logic iSDA,
   output logic oSDA,
   output logic oSCL_RISE,
   output logic oSCL_FALL,
   output logic oSTART,
   output logic oSTOP
);

   logic [SYNC_STAGES-1:0] sclPipe;
   logic [SYNC_STAGES-1:0] sdaPipe;
   logic                   prevScl;
   logic                   prevSda;
   logic                   sScl;
   logic                   sSda;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         sclPipe <= '1;
         sdaPipe <= '1;
         prevScl <= 1'b1;
         prevSda <= 1'b1;
      end else begin
         sclPipe <= {sclPipe[SYNC_STAGES-2:0], iSCL};
         sdaPipe <= {sdaPipe[SYNC_STAGES-2:0], iSDA};
         prevScl <= sScl;
         prevSda <= sSda;
      end
   end

   assign sScl = sclPipe[SYNC_STAGES-1];
   assign sSda = sdaPipe[SYNC_STAGES-1];

   assign oSDA      = sSda;
   assign oSCL_RISE = sScl & ~prevScl;
   assign oSCL_FALL = ~sScl & prevScl;
   // SCL must be high in both cycles so an SCL edge never reads as START/STOP.
   assign oSTART    = prevSda & ~sSda & prevScl & sScl;
   assign oSTOP     = ~prevSda & sSda & prevScl & sScl;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C register responder: decodes [SLAVE_ADDR, SUB_ADDR, DATA...] write frames
// into register-file write strobes and serves combined-format reads.
//   iCLK, iRST   : system clock (>= 20x SCL), synchronous active-high reset
//   iSCL, iSDA   : raw pad inputs
//   oSDA_OE      : 1 = pull SDA low, 0 = release
//   oWR_EN       : one-cycle write strobe, oWR_ADDR/oWR_DATA valid with it
//   oRD_ADDR     : register pointer; iRD_DATA returns that register
//   oBUSY        : high from START until STOP
//   oSTART_ERR   : pulse when START/STOP cuts a byte short
//   oDBG_STATE   : current FSM state (state_t encoding)
//
// Register-file interface: oWR_EN is a pure strobe with no back-pressure; the
// register file must accept the write in the cycle oWR_EN is high. On the read
// side oRD_ADDR is held steady and iRD_DATA must follow it within one iCLK;
// data is only captured on an SCL fall, many cycles after the pointer moves.
module i2c_reg_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = CODEC_DEV_ADDR,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iSCL,
   input  logic       iSDA,
   output logic       oSDA_OE,
   output logic       oWR_EN,
   output logic [7:0] oWR_ADDR,
   output logic [7:0] oWR_DATA,
   output logic [7:0] oRD_ADDR,
   input  logic [7:0] iRD_DATA,
   output logic       oBUSY,
   output logic       oSTART_ERR,
   output logic [3:0] oDBG_STATE
);

   logic sSda;
   logic sclRise;
   logic sclFall;
   logic startDet;
   logic stopDet;

   i2c_bus_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) uBusSync (
      .iCLK      (iCLK),
      .iRST      (iRST),
      .iSCL      (iSCL),
      .iSDA      (iSDA),
      .oSDA      (sSda),
      .oSCL_RISE (sclRise),
      .oSCL_FALL (sclFall),
      .oSTART    (startDet),
      .oSTOP     (stopDet)
   );

   state_t     state,    stateNext;
   logic [3:0] bitCnt,   bitCntNext;    // SCL rises seen in the current byte
   logic [7:0] shiftReg, shiftNext;
   logic       rwFlag,   rwNext;
   logic [7:0] pointer,  pointerNext;
   logic       ackPhase, ackPhaseNext;  // ACK slot: 0 = before drive, 1 = driving
   logic       sdaOe,    sdaOeNext;
   logic       wrEn,     wrEnNext;
   logic [7:0] wrAddr,   wrAddrNext;
   logic [7:0] wrData,   wrDataNext;
   logic       busy,     busyNext;
   logic       startErr, startErrNext;

   logic [7:0] rxByte;
   logic       partialByte;

   assign rxByte = {shiftReg[6:0], sSda};

   // START/STOP can only happen with SCL high, i.e. after the rise that opens
   // the next bit slot, so the bits actually completed are bitCnt-1. Counting
   // this way keeps a normal STOP or repeated START (one rise into a fresh
   // byte) from being flagged, while a byte cut after 1..7 bits is.
   assign partialByte = (bitCnt >= 4'd2) && (bitCnt <= 4'd8);

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state    <= IDLE;
         bitCnt   <= 4'd0;
         shiftReg <= 8'd0;
         rwFlag   <= I2C_WRITE;
         pointer  <= 8'd0;
         ackPhase <= 1'b0;
         sdaOe    <= 1'b0;
         wrEn     <= 1'b0;
         wrAddr   <= 8'd0;
         wrData   <= 8'd0;
         busy     <= 1'b0;
         startErr <= 1'b0;
      end else begin
         state    <= stateNext;
         bitCnt   <= bitCntNext;
         shiftReg <= shiftNext;
         rwFlag   <= rwNext;
         pointer  <= pointerNext;
         ackPhase <= ackPhaseNext;
         sdaOe    <= sdaOeNext;
         wrEn     <= wrEnNext;
         wrAddr   <= wrAddrNext;
         wrData   <= wrDataNext;
         busy     <= busyNext;
         startErr <= startErrNext;
      end
   end

   always_comb begin
      stateNext    = state;
      bitCntNext   = bitCnt;
      shiftNext    = shiftReg;
      rwNext       = rwFlag;
      pointerNext  = pointer;
      ackPhaseNext = ackPhase;
      sdaOeNext    = sdaOe;
      wrEnNext     = 1'b0;
      wrAddrNext   = wrAddr;
      wrDataNext   = wrData;
      busyNext     = busy;
      startErrNext = 1'b0;

      if (startDet) begin
         stateNext    = ADDR;
         bitCntNext   = 4'd0;
         ackPhaseNext = 1'b0;
         sdaOeNext    = 1'b0;
         busyNext     = 1'b1;
         startErrNext = partialByte;
      end else if (stopDet) begin
         stateNext    = IDLE;
         bitCntNext   = 4'd0;
         ackPhaseNext = 1'b0;
         sdaOeNext    = 1'b0;
         busyNext     = 1'b0;
         startErrNext = partialByte;
      end else begin
         case (state)
            IDLE: ;

            ADDR: begin
               if (sclRise) begin
                  shiftNext  = rxByte;
                  bitCntNext = bitCnt + 4'd1;
                  if (bitCnt == 4'd7) begin
                     bitCntNext = 4'd0;
                     if (rxByte[7:1] == DEV_ADDR) begin
                        rwNext    = rxByte[0];
                        stateNext = ADDR_ACK;
                     end else begin
                        stateNext = WAIT_STOP;
                     end
                  end
               end
            end

            SUB: begin
               if (sclRise) begin
                  shiftNext  = rxByte;
                  bitCntNext = bitCnt + 4'd1;
                  if (bitCnt == 4'd7) begin
                     bitCntNext  = 4'd0;
                     pointerNext = rxByte;
                     stateNext   = SUB_ACK;
                  end
               end
            end

            WDATA: begin
               if (sclRise) begin
                  shiftNext  = rxByte;
                  bitCntNext = bitCnt + 4'd1;
                  if (bitCnt == 4'd7) begin
                     bitCntNext  = 4'd0;
                     wrEnNext    = 1'b1;
                     wrAddrNext  = pointer;
                     wrDataNext  = rxByte;
                     pointerNext = pointer + 8'd1;
                     stateNext   = WDATA_ACK;
                  end
               end
            end

            // First fall after the byte pulls SDA low for the ACK clock, the
            // second fall ends the slot.
            ADDR_ACK, SUB_ACK, WDATA_ACK: begin
               if (sclFall) begin
                  if (!ackPhase) begin
                     sdaOeNext    = 1'b1;
                     ackPhaseNext = 1'b1;
                  end else begin
                     sdaOeNext    = 1'b0;
                     ackPhaseNext = 1'b0;
                     bitCntNext   = 4'd0;
                     if (state == ADDR_ACK) begin
                        if (rwFlag == I2C_READ) begin
                           shiftNext = iRD_DATA;
                           sdaOeNext = ~iRD_DATA[7];
                           stateNext = RDATA;
                        end else begin
                           stateNext = SUB;
                        end
                     end else begin
                        stateNext = WDATA;
                     end
                  end
               end
            end

            // The MSB of shiftReg is on the bus; each fall after a sampled bit
            // shifts the next one up. The fall after the 8th bit frees SDA.
            RDATA: begin
               if (sclRise) begin
                  bitCntNext = bitCnt + 4'd1;
               end else if (sclFall && (bitCnt != 4'd0)) begin
                  if (bitCnt == 4'd8) begin
                     sdaOeNext  = 1'b0;
                     bitCntNext = 4'd0;
                     stateNext  = RACK;
                  end else begin
                     shiftNext = {shiftReg[6:0], 1'b0};
                     sdaOeNext = ~shiftReg[6];
                  end
               end
            end

            RACK: begin
               if (sclRise) begin
                  pointerNext = pointer + 8'd1;
                  if (sSda) begin
                     stateNext = WAIT_STOP;
                  end else begin
                     ackPhaseNext = 1'b1;
                  end
               end else if (sclFall && ackPhase) begin
                  ackPhaseNext = 1'b0;
                  shiftNext    = iRD_DATA;
                  sdaOeNext    = ~iRD_DATA[7];
                  stateNext    = RDATA;
               end
            end

            WAIT_STOP: sdaOeNext = 1'b0;

            default: stateNext = IDLE;
         endcase
      end
   end

   assign oSDA_OE    = sdaOe;
   assign oWR_EN     = wrEn;
   assign oWR_ADDR   = wrAddr;
   assign oWR_DATA   = wrData;
   assign oRD_ADDR   = pointer;
   assign oBUSY      = busy;
   assign oSTART_ERR = startErr;
   assign oDBG_STATE = state;

endmodule

// File: tb/tb_i2c_reg_slave.sv
module tb_i2c_reg_slave;
   import i2c_pkg::*;

   localparam int Q = 10;  // iCLK cycles per SCL quarter period

   // ---------------- clock / reset ----------------
   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic scl  = 1'b1;
   logic sdaM = 1'b1;      // master side of the open-drain SDA

   always #5 clk = ~clk;

   logic       sdaOe, wrEn, busy, startErr, sdaBus;
   logic [7:0] wrAddr, wrData, rdAddr, rdData;
   logic [3:0] dbgState;
   logic [7:0] regFile [256];

   assign sdaBus = sdaM & ~sdaOe;
   assign rdData = regFile[rdAddr];

   i2c_reg_slave dut (
      .iCLK       (clk),
      .iRST       (rst),
      .iSCL       (scl),
      .iSDA       (sdaBus),
      .oSDA_OE    (sdaOe),
      .oWR_EN     (wrEn),
      .oWR_ADDR   (wrAddr),
      .oWR_DATA   (wrData),
      .oRD_ADDR   (rdAddr),
      .iRD_DATA   (rdData),
      .oBUSY      (busy),
      .oSTART_ERR (startErr),
      .oDBG_STATE (dbgState)
   );

   // ---------------- scoreboard ----------------
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   int gotIdx    = 0;
   int nChecks   = 0;
   int nFail     = 0;
   int errPulses = 0;
   int oeSeen    = 0;

   always @(negedge clk) begin
      if (wrEn)     got_q.push_back({wrAddr, wrData});
      if (startErr) errPulses++;
      if (sdaOe)    oeSeen++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_wr_count"}, 32'(got_q.size() - gotIdx), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (gotIdx + i < got_q.size())
            check({tag, "_wr"}, 32'(got_q[gotIdx + i]), 32'(exp_q[i]));
      gotIdx = got_q.size();
      exp_q.delete();
   endtask

   // ---------------- driver tasks ----------------
   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sdaM = 1'b1; wq();
      scl  = 1'b1; wq();
      sdaM = 1'b0; wq();
      scl  = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      sdaM = 1'b0; wq();
      scl  = 1'b1; wq();
      sdaM = 1'b1; wq();
   endtask

   task automatic clock_bit(input logic b, output logic seen);
      sdaM = b;    wq();
      scl  = 1'b1; wq();
      seen = sdaBus;
      wq();
      scl  = 1'b0; wq();
   endtask

   task automatic write_byte(input logic [7:0] b, input string tag, input logic expAck);
      logic seen;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], seen);
      clock_bit(1'b1, seen);
      check(tag, 32'(seen), 32'(expAck));
   endtask

   task automatic read_byte(input logic ackBit, output logic [7:0] d);
      logic seen;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, seen);
         d[i] = seen;
      end
      clock_bit(ackBit, seen);
      sdaM = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [7:0] rd;
      logic       seen;
      logic [7:0] addrByte;
      int         errBase;
      int         oeBase;

      for (int i = 0; i < 256; i++) regFile[i] = 8'(i);
      regFile[8'h07] = 8'hA5;
      regFile[8'h08] = 8'h3C;

      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_sda_oe",    32'(sdaOe),    32'd0);
      check("rst_wr_en",     32'(wrEn),     32'd0);
      check("rst_wr_addr",   32'(wrAddr),   32'd0);
      check("rst_wr_data",   32'(wrData),   32'd0);
      check("rst_rd_addr",   32'(rdAddr),   32'd0);
      check("rst_busy",      32'(busy),     32'd0);
      check("rst_start_err", 32'(startErr), 32'd0);
      check("rst_state",     32'(dbgState), 32'(IDLE));
      wq();
      errBase = errPulses;

      // 1: basic write 34 0C 00
      i2c_start();
      check("t1_busy_start", 32'(busy), 32'd1);
      write_byte(8'h34, "t1_ack_addr", 1'b0);
      check("t1_state_sub", 32'(dbgState), 32'(SUB));
      write_byte(8'h0C, "t1_ack_sub", 1'b0);
      check("t1_ptr_sub", 32'(rdAddr), 32'h0C);
      write_byte(8'h00, "t1_ack_data", 1'b0);
      i2c_stop();
      wq();
      check("t1_busy_stop", 32'(busy), 32'd0);
      check("t1_ptr_end",   32'(rdAddr), 32'h0D);
      exp_q.push_back(16'h0C00);
      check_writes("t1");

      // 2: foreign address ignored, next frame accepted
      oeBase = oeSeen;
      i2c_start();
      write_byte(8'h40, "t2_nack_addr", 1'b1);
      check("t2_state_wait", 32'(dbgState), 32'(WAIT_STOP));
      write_byte(8'h07, "t2_nack_sub",  1'b1);
      write_byte(8'h01, "t2_nack_data", 1'b1);
      i2c_stop();
      wq();
      check("t2_oe_never", 32'(oeSeen - oeBase), 32'd0);
      check_writes("t2_foreign");
      i2c_start();
      write_byte(8'h34, "t2_ack_addr", 1'b0);
      write_byte(8'h10, "t2_ack_sub",  1'b0);
      write_byte(8'h5A, "t2_ack_data", 1'b0);
      i2c_stop();
      wq();
      exp_q.push_back(16'h105A);
      check_writes("t2_follow");

      // 3: burst write with pointer wrap
      i2c_start();
      write_byte(8'h34, "t3_ack_addr", 1'b0);
      write_byte(8'hFE, "t3_ack_sub",  1'b0);
      write_byte(8'h11, "t3_ack_d0",   1'b0);
      write_byte(8'h22, "t3_ack_d1",   1'b0);
      write_byte(8'h33, "t3_ack_d2",   1'b0);
      i2c_stop();
      wq();
      check("t3_ptr_wrap", 32'(rdAddr), 32'h01);
      exp_q.push_back(16'hFE11);
      exp_q.push_back(16'hFF22);
      exp_q.push_back(16'h0033);
      check_writes("t3");

      // 4: combined read from 0x07
      i2c_start();
      write_byte(8'h34, "t4_ack_addr_w", 1'b0);
      write_byte(8'h07, "t4_ack_sub",    1'b0);
      i2c_start();
      check("t4_state_rs", 32'(dbgState), 32'(ADDR));
      write_byte(8'h35, "t4_ack_addr_r", 1'b0);
      read_byte(1'b0, rd);
      check("t4_rd0",      32'(rd),     32'hA5);
      check("t4_ptr_rd0",  32'(rdAddr), 32'h08);
      read_byte(1'b1, rd);
      check("t4_rd1",      32'(rd),     32'h3C);
      check("t4_oe_nack",  32'(sdaOe),  32'd0);
      check("t4_state_ws", 32'(dbgState), 32'(WAIT_STOP));
      i2c_stop();
      wq();
      check("t4_ptr_end",  32'(rdAddr), 32'h09);
      check("t4_busy",     32'(busy),   32'd0);
      check_writes("t4");
      check("t1_4_no_start_err", 32'(errPulses - errBase), 32'd0);

      // 5: STOP after 4 data bits
      errBase = errPulses;
      i2c_start();
      write_byte(8'h34, "t5_ack_addr", 1'b0);
      write_byte(8'h20, "t5_ack_sub",  1'b0);
      clock_bit(1'b1, seen);
      clock_bit(1'b0, seen);
      clock_bit(1'b1, seen);
      clock_bit(1'b0, seen);
      i2c_stop();
      wq();
      check("t5_start_err", 32'(errPulses - errBase), 32'd1);
      check("t5_state",     32'(dbgState), 32'(IDLE));
      check("t5_busy",      32'(busy),     32'd0);
      check("t5_ptr",       32'(rdAddr),   32'h20);
      check_writes("t5");

      // 6: reset while driving ACK
      i2c_start();
      addrByte = 8'h34;
      for (int i = 7; i >= 0; i--) clock_bit(addrByte[i], seen);
      check("t6_ack_driven", 32'(sdaOe), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_oe_release", 32'(sdaOe), 32'd0);
      @(negedge clk);
      check("t6_wr_en",     32'(wrEn),     32'd0);
      check("t6_wr_addr",   32'(wrAddr),   32'd0);
      check("t6_wr_data",   32'(wrData),   32'd0);
      check("t6_rd_addr",   32'(rdAddr),   32'd0);
      check("t6_busy",      32'(busy),     32'd0);
      check("t6_start_err", 32'(startErr), 32'd0);
      check("t6_state",     32'(dbgState), 32'(IDLE));
      repeat (3) @(negedge clk);
      rst  = 1'b0;
      sdaM = 1'b1;
      scl  = 1'b1;
      wq();
      i2c_start();
      write_byte(8'h34, "t6_ack_addr", 1'b0);
      write_byte(8'h44, "t6_ack_sub",  1'b0);
      write_byte(8'h99, "t6_ack_data", 1'b0);
      i2c_stop();
      wq();
      check("t6_ptr_end", 32'(rdAddr), 32'h45);
      exp_q.push_back(16'h4499);
      check_writes("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
